// File: rtl/dmem_responder.sv
// Data-side memory responder: word-addressed data RAM plus a camera capture
// window that packs 8-bit pixels into 32-bit words queued in a FIFO.
module dmem_responder #(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  input  logic        read_enable,
  output logic [31:0] read_data,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        pix_ready,
  output logic        irq_cam
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [29:0] CAM_DATA_W   = 30'h0000_4000;
  localparam logic [29:0] CAM_STATUS_W = 30'h0000_4001;
  localparam logic [29:0] CAM_CTRL_W   = 30'h0000_4002;

  logic [31:0]   ram_q  [RAM_WORDS];
  logic [31:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    pack_cnt_q, pack_cnt_d;
  logic [23:0]   pack_q, pack_d;
  logic          enable_q, enable_d;
  logic          overflow_q, overflow_d;

  logic ram_sel, data_sel, status_sel, ctrl_sel;
  logic ctrl_wr, flush, accept, push, pop, store;
  logic fifo_full, fifo_empty;
  logic [31:0] push_word;

  assign ram_sel    = (address[31:16] == 16'h0000);
  assign data_sel   = (address[31:2] == CAM_DATA_W);
  assign status_sel = (address[31:2] == CAM_STATUS_W);
  assign ctrl_sel   = (address[31:2] == CAM_CTRL_W);

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign ctrl_wr    = write_enable & ctrl_sel;
  assign flush      = ctrl_wr & write_data[2];
  assign accept     = pix_valid & enable_q;
  // The fourth byte bypasses the packer register and goes straight into the word.
  assign push_word  = {pix_data, pack_q};
  assign push       = accept & (pack_cnt_q == 2'd3) & ~flush;
  assign pop        = read_enable & data_sel & ~fifo_empty & ~flush;
  // A pop frees the slot, so a push at full still lands when paired with one.
  assign store      = push & (pop | ~fifo_full);

  assign pix_ready  = enable_q;
  assign irq_cam    = enable_q & (count_q >= CW'(FIFO_DEPTH / 2));

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pack_cnt_d = pack_cnt_q;
    pack_d     = pack_q;
    enable_d   = enable_q;
    overflow_d = overflow_q;
    if (ctrl_wr) enable_d = write_data[0];
    if (ctrl_wr & write_data[1]) overflow_d = 1'b0;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      pack_cnt_d = 2'd0;
      pack_d     = '0;
    end else begin
      if (accept) begin
        pack_cnt_d = pack_cnt_q + 2'd1;
        case (pack_cnt_q)
          2'd0:    pack_d[7:0]   = pix_data;
          2'd1:    pack_d[15:8]  = pix_data;
          2'd2:    pack_d[23:16] = pix_data;
          default: pack_d        = pack_q;
        endcase
      end
      if (store) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      if (push & fifo_full & ~pop) overflow_d = 1'b1;
      case ({store, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage arrays carry no reset so they map onto plain RAM.
  always_ff @(posedge clk) begin
    if (write_enable & ram_sel) ram_q[address[AW+1:2]] <= write_data;
    if (store) fifo_q[wr_ptr_q] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pack_cnt_q <= 2'd0;
      pack_q     <= '0;
      enable_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pack_cnt_q <= pack_cnt_d;
      pack_q     <= pack_d;
      enable_q   <= enable_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    read_data = '0;
    if (ram_sel)
      read_data = ram_q[address[AW+1:2]];
    else if (data_sel)
      read_data = fifo_empty ? 32'h0 : fifo_q[rd_ptr_q];
    else if (status_sel)
      read_data = {18'b0, pack_cnt_q, enable_q, overflow_q, fifo_full, fifo_empty, 8'(count_q)};
    else if (ctrl_sel)
      read_data = {31'b0, enable_q};
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-side memory responder for the pipelined ARM core. It serves the core's memory-stage requests: address, write data, write enable and read strobe in, read data out. It decodes them into a word-addressed data RAM and a camera capture window. The camera side packs incoming 8-bit pixels into 32-bit words and queues them in a word FIFO, which the core drains by loads from a memory-mapped data register.

## Interface
Parameters:
- RAM_WORDS, 1024, data RAM depth in 32-bit words (power of two, ≤ 16384)
- FIFO_DEPTH, 16, camera word FIFO depth (power of two, 2..128)

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-low reset
- address  in  32  byte address from core memory stage (ALU result)
- write_data  in  32  store data
- write_enable  in  1  store strobe, one cycle per store
- read_enable  in  1  load strobe (MemToReg of the memory stage), one cycle per load
- read_data  out  32  load data, combinational from address
- pix_valid  in  1  camera pixel present
- pix_data  in  8  camera pixel
- pix_ready  out  1  equals capture-enable bit
- irq_cam  out  1  high while FIFO count ≥ FIFO_DEPTH/2 and enable=1

## Operation
- Decode uses address[1:0] ignored (word-aligned).
- RAM: address[31:16]==0; index address[log2(RAM_WORDS)+1:2]. Upper bits within the region alias.
- CAM_DATA=0x0001_0000: read pops FIFO.
- CAM_STATUS=0x0001_0004: read-only.
- CAM_CTRL=0x0001_0008: read/write.
- Any other address is unmapped: reads return 0, writes are ignored.
- RAM write on rising clk when write_enable=1 and address is in the RAM region. Read is asynchronous. RAM contents are not cleared by reset.
- CAM_CTRL write: bit0 = enable (stored); bit1 = clear overflow (self-clearing, reads 0); bit2 = flush (empties FIFO and resets the packer, self-clearing). Read returns {31'b0, enable}.
- CAM_STATUS: [7:0] FIFO count, [8] empty, [9] full, [10] overflow (sticky), [11] enable, [13:12] pack_cnt, others 0.
- Packer: byte lanes fill little-endian. pixel 0→[7:0], 1→[15:8], 2→[23:16], 3→[31:24]. Each accepted pixel (pix_valid & pix_ready) stores its byte at lane pack_cnt and increments pack_cnt mod 4. On the 4th byte, the assembled word is pushed to the FIFO in the same edge.
- Push when FIFO full and no simultaneous pop: word dropped, overflow←1, pack_cnt still wraps to 0.
- CAM_DATA read (read_enable=1 & address==CAM_DATA): read_data = FIFO head; pop on the same edge.
- CAM_DATA read when empty: read_data = 0, no pop, no state change.
- CAM_DATA with no read_enable: read_data shows head (0 if empty), no pop.
- Simultaneous push and pop: both occur, count unchanged, no overflow, even when full.
- The pop of the only entry while a push occurs leaves the new word as head next cycle.
- Disabling (enable←0) holds the partial packer contents and pack_cnt; re-enable resumes filling.
- Flush has priority over a same-cycle push and pop. Both are discarded; overflow is unaffected.
- write_enable and read_enable both high: the write is performed, and the read obeys the rules above.

## Timing
- Reset (reset=0 at rising clk): enable=0, pack_cnt=0, FIFO count=0, pointers=0, overflow=0, packer bytes=0.
- Outputs after reset: pix_ready=0, irq_cam=0, read_data reflects the new state (CAM_STATUS reads 0x0000_0100).
- Reset mid-packet or mid-drain discards everything; the RAM is retained.
- Store latency: written data is readable by a load in the next cycle.
- Loads: zero-cycle latency; read_data is valid in the same cycle the address is presented.
- Pixel to data: the 4th pixel accepted at edge N is visible at CAM_DATA / in count after edge N. irq_cam updates at the same edge.
- CAM_CTRL write at edge N: pix_ready changes after edge N. A pixel presented in the cycle of a disable write is still accepted.
- Throughput: one pixel per cycle sustained; one pop per cycle.

## Test plan
- Reset and RAM: assert reset=0 for 2 cycles → CAM_STATUS=0x0000_0100, pix_ready=0, irq_cam=0. Store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 → 0xDEADBEEF. Load 0x0002_0000 → 0.
- Packing: write CAM_CTRL=1, then stream pixels 0x11,0x22,0x33,0x44 → count=1. Read CAM_DATA → 0x44332211, then count=0 and empty=1.
- Overflow: FIFO_DEPTH=16, stream 68 pixels with no reads → full=1, count=16, overflow=1. FIFO content equals the first 16 words. Write CAM_CTRL=0x3 → overflow=0, enable stays 1.
- Simultaneous push/pop at full: with count=16, pop in the same cycle the 4th byte arrives → count stays 16, overflow=0, new word at tail.
- Empty read and partial hold: load CAM_DATA when empty → 0, count stays 0. Send 2 pixels, disable, then wait 10 cycles → pack_cnt=2. Re-enable and send 2 more → one complete word.
- Flush and mid-operation reset: with count=5 and pack_cnt=3, write CAM_CTRL=0x5 → count=0, pack_cnt=0. Refill to count=9 (irq_cam=1), then pulse reset → irq_cam=0 and count=0, while previously stored RAM words are unchanged.
